// File: rtl/hssi_mac_xcvr_reset_seq.sv
// ---------------------------------------------------------------------------
// hssi_mac_xcvr_reset_seq
//
// MAC-side transceiver bring-up sequencer. It walks the FIU transceiver
// through a fixed sequence:
//   full reset -> init handshake -> TX PLL lock -> TX digital release
//   -> RX CDR lock -> RX digital release -> link up.
// Lock loss and lock timeouts trigger automatic recovery. Every recovery
// event is counted in a saturating retry counter.
//
// Ports
//   clk, reset              : clock and synchronous active-high reset
//   restart                 : one-cycle request to re-run the whole sequence
//   loopback_en             : serial loopback request, registered per lane
//   f2m_init_done           : FIU init handshake complete
//   f2m_tx_pll_locked       : TX PLL lock
//   f2m_tx_cal_busy         : TX calibration in progress
//   f2m_rx_cal_busy         : RX calibration in progress
//   f2m_rx_is_lockedtodata  : per-lane CDR lock
//   m2f_init_start          : init request to the FIU
//   m2f_tx/rx_*reset        : per-lane resets (always all-ones or all-zeros)
//   m2f_rx_seriallpbken     : per-lane serial loopback enable
//   m2f_rx_set_lockto*      : CDR mode forcing, tied low (automatic mode)
//   xcvr_ready              : link up, all resets released
//   seq_state               : current state encoding
//   retry_cnt               : saturating count of recovery events
// ---------------------------------------------------------------------------
module hssi_mac_xcvr_reset_seq #(
    parameter int NUM_LN              = 4,
    parameter int ANALOG_RST_CYCLES   = 32,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              loopback_en,
    input  logic              f2m_init_done,
    input  logic              f2m_tx_pll_locked,
    input  logic              f2m_tx_cal_busy,
    input  logic              f2m_rx_cal_busy,
    input  logic [NUM_LN-1:0] f2m_rx_is_lockedtodata,
    output logic              m2f_init_start,
    output logic [NUM_LN-1:0] m2f_tx_analogreset,
    output logic [NUM_LN-1:0] m2f_tx_digitalreset,
    output logic [NUM_LN-1:0] m2f_rx_analogreset,
    output logic [NUM_LN-1:0] m2f_rx_digitalreset,
    output logic [NUM_LN-1:0] m2f_rx_seriallpbken,
    output logic [NUM_LN-1:0] m2f_rx_set_locktoref,
    output logic [NUM_LN-1:0] m2f_rx_set_locktodata,
    output logic              xcvr_ready,
    output logic [2:0]        seq_state,
    output logic [7:0]        retry_cnt
);

    localparam logic [2:0] S_RST_ALL = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_TX_PLL  = 3'd2;
    localparam logic [2:0] S_TX_DIG  = 3'd3;
    localparam logic [2:0] S_RX_CDR  = 3'd4;
    localparam logic [2:0] S_RX_DIG  = 3'd5;
    localparam logic [2:0] S_UP      = 3'd6;
    localparam logic [2:0] S_RX_RST  = 3'd7;

    // The shared counter must reach the larger of the two dwell limits.
    localparam int CNT_MAX = (LOCK_TIMEOUT_CYCLES > ANALOG_RST_CYCLES) ?
                             LOCK_TIMEOUT_CYCLES : ANALOG_RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int QCNT_W  = $clog2(LOCK_STABLE_CYCLES + 1);

    // Compare against the value held during the last cycle of the dwell,
    // so the state lasts exactly N cycles.
    localparam logic [CNT_W-1:0]  ARST_LAST = CNT_W'(ANALOG_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [QCNT_W-1:0] QCNT_SAT  = QCNT_W'(LOCK_STABLE_CYCLES);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [QCNT_W-1:0] qcnt_q, qcnt_d;
    logic [7:0]        retry_q, retry_d;
    logic [NUM_LN-1:0] lpbk_q;

    logic              lock_cond;
    logic [QCNT_W-1:0] qcnt_inc;
    logic [QCNT_W-1:0] qcnt_nxt;
    logic              lock_ok;
    logic              arst_done;
    logic              tmo;
    logic              retry_evt;
    logic              clr_cnt;

    logic tx_a_rst, tx_d_rst, rx_a_rst, rx_d_rst;

    // ------------------------------------------------------------------
    // Lock qualification: the state's lock condition must hold for
    // LOCK_STABLE_CYCLES consecutive cycles. The transition fires in the
    // cycle whose increment reaches the limit.
    // ------------------------------------------------------------------
    always_comb begin
        lock_cond = 1'b0;
        case (state_q)
            S_TX_PLL: lock_cond = f2m_tx_pll_locked & ~f2m_tx_cal_busy;
            S_RX_CDR: lock_cond = f2m_tx_pll_locked & ~f2m_rx_cal_busy &
                                  (&f2m_rx_is_lockedtodata);
            default:  lock_cond = 1'b0;
        endcase

        qcnt_inc  = (qcnt_q == QCNT_SAT) ? QCNT_SAT : qcnt_q + QCNT_W'(1);
        qcnt_nxt  = lock_cond ? qcnt_inc : '0;
        lock_ok   = lock_cond && (qcnt_inc == QCNT_SAT);
        arst_done = (cnt_q == ARST_LAST);
        tmo       = (cnt_q == TMO_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        retry_evt = 1'b0;

        case (state_q)
            S_RST_ALL: if (arst_done) state_d = S_INIT;

            // No timeout here: the FIU owns the length of its init phase.
            S_INIT:    if (f2m_init_done) state_d = S_TX_PLL;

            // A lock that qualifies in the same cycle as the timeout wins.
            S_TX_PLL: begin
                if (lock_ok) begin
                    state_d = S_TX_DIG;
                end else if (tmo) begin
                    state_d   = S_RST_ALL;
                    retry_evt = 1'b1;
                end
            end

            S_TX_DIG:  state_d = S_RX_CDR;

            S_RX_CDR: begin
                if (lock_ok) begin
                    state_d = S_RX_DIG;
                end else if (tmo) begin
                    state_d   = S_RX_RST;
                    retry_evt = 1'b1;
                end
            end

            S_RX_DIG:  state_d = S_UP;

            // PLL loss means the TX side is gone too, so it takes priority.
            S_UP: begin
                if (!f2m_tx_pll_locked) begin
                    state_d   = S_RST_ALL;
                    retry_evt = 1'b1;
                end else if (!(&f2m_rx_is_lockedtodata)) begin
                    state_d   = S_RX_RST;
                    retry_evt = 1'b1;
                end
            end

            S_RX_RST: begin
                if (!f2m_tx_pll_locked) begin
                    state_d   = S_RST_ALL;
                    retry_evt = 1'b1;
                end else if (arst_done) begin
                    state_d = S_RX_CDR;
                end
            end

            default: state_d = S_RST_ALL;
        endcase

        // restart overrides everything and is not a recovery event.
        if (restart) begin
            state_d   = S_RST_ALL;
            retry_evt = 1'b0;
        end

        // restart also clears the counters when already in RST_ALL.
        clr_cnt = restart || (state_d != state_q);

        if (clr_cnt) begin
            cnt_d  = '0;
            qcnt_d = '0;
        end else begin
            cnt_d  = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);
            qcnt_d = qcnt_nxt;
        end

        retry_d = (retry_evt && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST_ALL;
            cnt_q   <= '0;
            qcnt_q  <= '0;
            retry_q <= '0;
            lpbk_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qcnt_q  <= qcnt_d;
            retry_q <= retry_d;
            lpbk_q  <= {NUM_LN{loopback_en}};
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode: resets release progressively as the sequence
    // advances; RX_RST re-asserts only the RX side.
    // ------------------------------------------------------------------
    always_comb begin
        tx_a_rst = 1'b1;
        tx_d_rst = 1'b1;
        rx_a_rst = 1'b1;
        rx_d_rst = 1'b1;
        case (state_q)
            S_RST_ALL, S_INIT: ;
            S_TX_PLL: tx_a_rst = 1'b0;
            S_TX_DIG: begin
                tx_a_rst = 1'b0;
                tx_d_rst = 1'b0;
            end
            S_RX_CDR: begin
                tx_a_rst = 1'b0;
                tx_d_rst = 1'b0;
                rx_a_rst = 1'b0;
            end
            S_RX_DIG, S_UP: begin
                tx_a_rst = 1'b0;
                tx_d_rst = 1'b0;
                rx_a_rst = 1'b0;
                rx_d_rst = 1'b0;
            end
            S_RX_RST: begin
                tx_a_rst = 1'b0;
                tx_d_rst = 1'b0;
            end
            default: ;
        endcase
    end

    assign m2f_init_start        = (state_q == S_INIT);
    assign xcvr_ready            = (state_q == S_UP);
    assign m2f_tx_analogreset    = {NUM_LN{tx_a_rst}};
    assign m2f_tx_digitalreset   = {NUM_LN{tx_d_rst}};
    assign m2f_rx_analogreset    = {NUM_LN{rx_a_rst}};
    assign m2f_rx_digitalreset   = {NUM_LN{rx_d_rst}};
    assign m2f_rx_seriallpbken   = lpbk_q;
    assign m2f_rx_set_locktoref  = '0;
    assign m2f_rx_set_locktodata = '0;
    assign seq_state             = state_q;
    assign retry_cnt             = retry_q;

endmodule

// File: tb/tb_hssi_mac_xcvr_reset_seq.sv
module tb_hssi_mac_xcvr_reset_seq;

    localparam int NL  = 4;
    localparam int ARC = 4;
    localparam int LSC = 8;
    localparam int LTC = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rs, lb, idone, pll, txcal, rxcal;
    logic [NL-1:0] lanes;

    logic          init_start, ready;
    logic [NL-1:0] txa, txd, rxa, rxd, lpbk, ltr, ltd;
    logic [2:0]    st;
    logic [7:0]    retry;

    hssi_mac_xcvr_reset_seq #(
        .NUM_LN(NL), .ANALOG_RST_CYCLES(ARC),
        .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTC)
    ) dut (
        .clk(clk), .reset(rst), .restart(rs), .loopback_en(lb),
        .f2m_init_done(idone), .f2m_tx_pll_locked(pll),
        .f2m_tx_cal_busy(txcal), .f2m_rx_cal_busy(rxcal),
        .f2m_rx_is_lockedtodata(lanes),
        .m2f_init_start(init_start),
        .m2f_tx_analogreset(txa), .m2f_tx_digitalreset(txd),
        .m2f_rx_analogreset(rxa), .m2f_rx_digitalreset(rxd),
        .m2f_rx_seriallpbken(lpbk),
        .m2f_rx_set_locktoref(ltr), .m2f_rx_set_locktodata(ltd),
        .xcvr_ready(ready), .seq_state(st), .retry_cnt(retry)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural reference model ----------------
    // Phase number, cycles spent in the phase, consecutive good-lock cycles.
    int   m_st, m_dwell, m_good, m_retry;
    logic m_lb;

    task automatic model_step();
        int nxt, g;
        bit ret;
        if (rst) begin
            m_st = 0; m_dwell = 0; m_good = 0; m_retry = 0; m_lb = 1'b0;
            return;
        end
        m_lb = lb;
        nxt = m_st; ret = 0; g = 0;
        case (m_st)
            0: if (m_dwell + 1 >= ARC) nxt = 1;
            1: if (idone) nxt = 2;
            2: begin
                g = (pll && !txcal) ? ((m_good + 1 > LSC) ? LSC : m_good + 1) : 0;
                if (g == LSC) nxt = 3;
                else if (m_dwell + 1 >= LTC) begin nxt = 0; ret = 1; end
            end
            3: nxt = 4;
            4: begin
                g = (pll && !rxcal && (lanes == '1)) ? ((m_good + 1 > LSC) ? LSC : m_good + 1) : 0;
                if (g == LSC) nxt = 5;
                else if (m_dwell + 1 >= LTC) begin nxt = 7; ret = 1; end
            end
            5: nxt = 6;
            6: begin
                if (!pll) begin nxt = 0; ret = 1; end
                else if (lanes != '1) begin nxt = 7; ret = 1; end
            end
            default: begin
                if (!pll) begin nxt = 0; ret = 1; end
                else if (m_dwell + 1 >= ARC) nxt = 4;
            end
        endcase
        if (rs) begin nxt = 0; ret = 0; end
        if (ret && m_retry < 255) m_retry++;
        if (rs || nxt != m_st) begin m_dwell = 0; m_good = 0; end
        else begin m_dwell++; m_good = g; end
        m_st = nxt;
    endtask

    // Reset release order: TX analog, TX digital, RX analog, RX digital.
    function automatic logic [40:0] exp_obs();
        logic a, b, c, d;
        a = (m_st <= 1);
        b = (m_st <= 2);
        c = (m_st <= 3) || (m_st == 7);
        d = (m_st <= 4) || (m_st == 7);
        return {3'(m_st), (m_st == 1), {NL{a}}, {NL{b}}, {NL{c}}, {NL{d}},
                {NL{m_lb}}, {NL{1'b0}}, {NL{1'b0}}, (m_st == 6), 8'(m_retry)};
    endfunction

    function automatic logic [40:0] act_obs();
        return {st, init_start, txa, txd, rxa, rxd, lpbk, ltr, ltd, ready, retry};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_step();
            check("model", 64'(act_obs()), 64'(exp_obs()));
        end
    endtask

    task automatic set_good();
        rst = 0; rs = 0; idone = 1; pll = 1; txcal = 0; rxcal = 0; lanes = '1;
    endtask

    // Reset, then run with good flags until the model reaches phase tgt.
    task automatic bring_to(input int tgt);
        int k;
        set_good();
        rst = 1; tick(2);
        rst = 0; k = 0;
        while (m_st != tgt && k < 300) begin tick(1); k++; end
        check("bring_to_timeout", 64'(m_st), 64'(tgt));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          rst, rs, idone, pll;
        logic [NL-1:0] lanes;
        int            ncyc;
        logic [2:0]    e_st;
        logic          e_rdy;
        logic [7:0]    e_retry;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic i, logic p, logic [NL-1:0] l,
                                int n, logic [2:0] es, logic er, logic [7:0] et);
        vec_t v;
        v.rst = r; v.rs = s; v.idone = i; v.pll = p; v.lanes = l;
        v.ncyc = n; v.e_st = es; v.e_rdy = er; v.e_retry = et;
        return v;
    endfunction

    logic [7:0] r_save;

    initial begin
        rst = 1; rs = 0; lb = 0; idone = 0; pll = 1; txcal = 0; rxcal = 0; lanes = '1;
        m_st = 0; m_dwell = 0; m_good = 0; m_retry = 0; m_lb = 0;

        // Nominal bring-up, CDR loss in UP, then simultaneous PLL+CDR loss.
        tbl.push_back(mk(1, 0, 0, 1, 4'hF, 2, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'hF, 3, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'hF, 1, 3'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'hF, 2, 3'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 1, 3'd2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 7, 3'd2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 1, 3'd3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 1, 3'd4, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 7, 3'd4, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 1, 3'd5, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 1, 3'd6, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 5, 3'd6, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hD, 1, 3'd7, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 3, 3'd7, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 1, 3'd4, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 8, 3'd5, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 1, 3'd6, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 4'hD, 1, 3'd0, 0, 2));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; rs = tbl[i].rs; idone = tbl[i].idone;
            pll = tbl[i].pll; lanes = tbl[i].lanes;
            tick(tbl[i].ncyc);
            check($sformatf("tbl%0d_state", i), 64'(st), 64'(tbl[i].e_st));
            check($sformatf("tbl%0d_ready", i), 64'(ready), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_retry", i), 64'(retry), 64'(tbl[i].e_retry));
        end

        // Glitching PLL during TX_PLL: qualification restarts.
        bring_to(2);
        tick(5);
        pll = 0; tick(1);
        check("glitch_state", 64'(st), 64'd2);
        pll = 1; tick(7);
        check("glitch_hold", 64'(st), 64'd2);
        tick(1);
        check("glitch_exit", 64'(st), 64'd3);

        // CDR timeout loop with lane 2 stuck low.
        bring_to(4);
        lanes = 4'hB;
        tick(LTC - 1);
        check("tmo_hold", 64'(st), 64'd4);
        tick(1);
        check("tmo_rxrst", 64'(st), 64'd7);
        check("tmo_retry1", 64'(retry), 64'd1);
        check("tmo_txrst", 64'({txa, txd}), 64'd0);
        tick(ARC - 1);
        check("rxrst_hold", 64'(st), 64'd7);
        tick(1);
        check("rxrst_exit", 64'(st), 64'd4);
        tick(LTC + ARC);
        check("tmo_retry2", 64'(retry), 64'd2);

        // restart pulse in RX_CDR.
        bring_to(4);
        lanes = 4'hF;
        tick(3);
        r_save = retry;
        rs = 1; tick(1); rs = 0;
        check("restart_state", 64'(st), 64'd0);
        check("restart_resets", 64'({txa, txd, rxa, rxd}), 64'hFFFF);
        check("restart_retry", 64'(retry), 64'(r_save));

        // 300 forced CDR timeouts saturate retry_cnt; then reset mid-RX_CDR.
        bring_to(4);
        lanes = 4'hB; lb = 1;
        tick(300 * (LTC + ARC));
        check("sat_retry", 64'(retry), 64'd255);
        check("sat_lpbk", 64'(lpbk), 64'hF);
        tick(10);
        check("mid_cdr", 64'(st), 64'd4);
        rst = 1; tick(1);
        check("rst_state", 64'(st), 64'd0);
        check("rst_resets", 64'({txa, txd, rxa, rxd}), 64'hFFFF);
        check("rst_misc", 64'({init_start, ready, retry, lpbk}), 64'd0);

        // Randomised traffic against the model.
        rst = 0; lanes = '1;
        for (int i = 0; i < 5000; i++) begin
            rst   = ($urandom_range(0, 599) == 0);
            rs    = ($urandom_range(0, 249) == 0);
            lb    = $urandom_range(0, 1);
            idone = ($urandom_range(0, 2) == 0);
            pll   = ($urandom_range(0, 59) != 0);
            txcal = ($urandom_range(0, 29) == 0);
            rxcal = ($urandom_range(0, 29) == 0);
            for (int l = 0; l < NL; l++) lanes[l] = ($urandom_range(0, 79) != 0);
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
